// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam logic [2:0]  ALIGN_MASK   = 3'b111;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Control half of the write-back bundle; the XLEN-wide data fields live beside it.
  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       Mem_to_Reg;
    logic [4:0] rd;
    logic       misaligned;
    logic       bus_error;
  } wb_ctrl_t;

  function automatic logic is_misaligned(input logic [2:0] low_bits);
    return |(low_bits & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating counter of WAIT cycles without acknowledge; flags the final allowed cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of completed ack-less WAIT cycles, so LAST marks the final one.
  assign expired = (count >= LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory request/ack access, branch resolution, registered write-back bundle.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            regWrite,
  input  logic            Mem_to_Reg,
  input  logic            Mem_Read,
  input  logic            Mem_Write,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [XLEN-1:0] pcbranch,
  input  logic [XLEN-1:0] Result,
  input  logic [XLEN-1:0] read_data_2,
  input  logic [4:0]      ex_rd,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_regWrite,
  output logic            wb_Mem_to_Reg,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_read_data,
  output logic            misaligned,
  output logic            bus_error
);

  state_t          state;
  wb_ctrl_t        wb_q;
  wb_ctrl_t        cap_ctrl;
  logic [XLEN-1:0] cap_result;
  logic            cap_load;
  logic            timer_expired;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != WAIT),
    .enable ((state == WAIT) && !dmem_ack),
    .expired(timer_expired)
  );

  assign stall         = (state == WAIT);
  assign wb_valid      = wb_q.valid;
  assign wb_regWrite   = wb_q.regWrite;
  assign wb_Mem_to_Reg = wb_q.Mem_to_Reg;
  assign wb_rd         = wb_q.rd;
  assign misaligned    = wb_q.misaligned;
  assign bus_error     = wb_q.bus_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wb_q          <= '0;
      cap_ctrl      <= '0;
      cap_result    <= '0;
      cap_load      <= 1'b0;
      pc_src        <= 1'b0;
      pc_target     <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
    end else begin
      wb_q.valid      <= 1'b0;
      wb_q.misaligned <= 1'b0;
      wb_q.bus_error  <= 1'b0;
      pc_src          <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (Branch) begin
              pc_src        <= Zero;
              pc_target     <= pcbranch;
              wb_q          <= '{valid: 1'b1, regWrite: 1'b0, Mem_to_Reg: Mem_to_Reg,
                                 rd: ex_rd, misaligned: 1'b0, bus_error: 1'b0};
              wb_alu_result <= Result;
              wb_read_data  <= '0;
            end else if (Mem_Read || Mem_Write) begin
              if (is_misaligned(Result[2:0])) begin
                wb_q          <= '{valid: 1'b1, regWrite: 1'b0, Mem_to_Reg: Mem_to_Reg,
                                   rd: ex_rd, misaligned: 1'b1, bus_error: 1'b0};
                wb_alu_result <= Result;
                wb_read_data  <= '0;
              end else begin
                state      <= WAIT;
                dmem_req   <= 1'b1;
                dmem_we    <= Mem_Write;
                dmem_addr  <= Result;
                dmem_wdata <= read_data_2;
                cap_ctrl   <= '{valid: 1'b1, regWrite: regWrite, Mem_to_Reg: Mem_to_Reg,
                                rd: ex_rd, misaligned: 1'b0, bus_error: 1'b0};
                cap_result <= Result;
                cap_load   <= !Mem_Write;
              end
            end else begin
              wb_q          <= '{valid: 1'b1, regWrite: regWrite, Mem_to_Reg: Mem_to_Reg,
                                 rd: ex_rd, misaligned: 1'b0, bus_error: 1'b0};
              wb_alu_result <= Result;
              wb_read_data  <= '0;
            end
          end
        end
        WAIT: begin
          // Ack is tested first so an ack on the final allowed cycle beats the timeout.
          if (dmem_ack) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            wb_q          <= cap_ctrl;
            wb_alu_result <= cap_result;
            wb_read_data  <= cap_load ? dmem_rdata : '0;
          end else if (timer_expired) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            wb_q          <= '{valid: 1'b1, regWrite: 1'b0, Mem_to_Reg: cap_ctrl.Mem_to_Reg,
                               rd: cap_ctrl.rd, misaligned: 1'b0, bus_error: 1'b1};
            wb_alu_result <= cap_result;
            wb_read_data  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, regWrite, Mem_to_Reg, Mem_Read, Mem_Write, Branch, Zero;
  logic [63:0] pcbranch, Result, read_data_2;
  logic [4:0]  ex_rd;
  logic        stall, pc_src;
  logic [63:0] pc_target;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        wb_valid, wb_regWrite, wb_Mem_to_Reg;
  logic [4:0]  wb_rd;
  logic [63:0] wb_alu_result, wb_read_data;
  logic        misaligned, bus_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .XLEN(64),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .regWrite(regWrite),
    .Mem_to_Reg(Mem_to_Reg), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Branch(Branch), .Zero(Zero), .pcbranch(pcbranch), .Result(Result),
    .read_data_2(read_data_2), .ex_rd(ex_rd), .stall(stall), .pc_src(pc_src),
    .pc_target(pc_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_Mem_to_Reg(wb_Mem_to_Reg), .wb_rd(wb_rd), .wb_alu_result(wb_alu_result),
    .wb_read_data(wb_read_data), .misaligned(misaligned), .bus_error(bus_error)
  );

  task automatic clear_inputs();
    ex_valid = 0; regWrite = 0; Mem_to_Reg = 0; Mem_Read = 0; Mem_Write = 0;
    Branch = 0; Zero = 0; pcbranch = '0; Result = '0; read_data_2 = '0; ex_rd = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic present(input logic rw, m2r, mr, mw, br, z,
                         input logic [63:0] res, wd, pcb, input logic [4:0] rd);
    ex_valid = 1; regWrite = rw; Mem_to_Reg = m2r; Mem_Read = mr; Mem_Write = mw;
    Branch = br; Zero = z; Result = res; read_data_2 = wd; pcbranch = pcb; ex_rd = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall, pc_src, pc_target, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid,
         wb_regWrite, wb_Mem_to_Reg, wb_rd, wb_alu_result, wb_read_data, misaligned,
         bus_error} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero (req=%b wb_valid=%b stall=%b)",
                           dmem_req, wb_valid, stall);
    end
    @(negedge clk) reset = 0;
  endtask

  task automatic test_alu();
    @(negedge clk) present(1, 0, 0, 0, 0, 0, 64'h2A, 64'h0, 64'h0, 5'd5);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall_pre: got %b expected 0", stall); end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_alu_result !== 64'h2A || wb_rd !== 5'd5 || wb_regWrite !== 1'b1) begin
      failures++; $display("FAIL alu_wb: valid=%b alu=%h rd=%0d rw=%b expected 1/2a/5/1",
                           wb_valid, wb_alu_result, wb_rd, wb_regWrite);
    end
    checks++;
    if (wb_read_data !== 64'h0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL alu_side: rdata=%h stall=%b req=%b expected 0/0/0",
                           wb_read_data, stall, dmem_req);
    end
    @(negedge clk) clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_pulse: wb_valid=%b expected 0", wb_valid); end
  endtask

  task automatic test_load();
    int stall_cycles = 0;
    bit req_stable = 1;
    @(negedge clk) present(1, 1, 1, 0, 0, 0, 64'h100, 64'h0, 64'h0, 5'd7);
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h100 || stall !== 1'b1) begin
      failures++; $display("FAIL load_req: req=%b we=%b addr=%h stall=%b expected 1/0/100/1",
                           dmem_req, dmem_we, dmem_addr, stall);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) present(1, 0, 0, 0, 0, 0, 64'h77, 64'h0, 64'h0, 5'd9);
      if (stall === 1'b1) stall_cycles++;
      if (dmem_req !== 1'b1 || dmem_addr !== 64'h100) req_stable = 0;
      dmem_ack = (i == 3);
      dmem_rdata = (i == 3) ? 64'hDEAD : 64'hBAD;
      @(posedge clk); #1;
    end
    checks++;
    if (!req_stable) begin failures++; $display("FAIL load_req_stable: got 0 expected 1"); end
    checks++;
    if (stall_cycles !== 3 || stall !== 1'b0) begin
      failures++; $display("FAIL load_stall: cycles=%0d stall_now=%b expected 3/0", stall_cycles, stall);
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_read_data !== 64'hDEAD || wb_Mem_to_Reg !== 1'b1 ||
        wb_rd !== 5'd7 || wb_alu_result !== 64'h100 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL load_wb: valid=%b rdata=%h m2r=%b rd=%0d alu=%h req=%b expected 1/dead/1/7/100/0",
                           wb_valid, wb_read_data, wb_Mem_to_Reg, wb_rd, wb_alu_result, dmem_req);
    end
    @(negedge clk) clear_inputs();
  endtask

  task automatic test_store();
    @(negedge clk) present(0, 0, 1, 1, 0, 0, 64'hF8, 64'h55, 64'h0, 5'd3);
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 64'h55 ||
        dmem_addr !== 64'hF8 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL store_req: req=%b we=%b wdata=%h addr=%h wbv=%b expected 1/1/55/f8/0",
                           dmem_req, dmem_we, dmem_wdata, dmem_addr, wb_valid);
    end
    @(negedge clk) begin clear_inputs(); dmem_ack = 1; dmem_rdata = 64'h1234; end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_regWrite !== 1'b0 || wb_read_data !== 64'h0 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL store_wb: valid=%b rw=%b rdata=%h req=%b expected 1/0/0/0",
                           wb_valid, wb_regWrite, wb_read_data, dmem_req);
    end
    @(negedge clk) clear_inputs();
  endtask

  task automatic test_misaligned();
    @(negedge clk) begin present(1, 1, 1, 0, 0, 0, 64'h103, 64'h0, 64'h0, 5'd4); dmem_ack = 1; end
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b0 || misaligned !== 1'b1 || wb_valid !== 1'b1 ||
        wb_regWrite !== 1'b0 || stall !== 1'b0 || bus_error !== 1'b0) begin
      failures++; $display("FAIL misaligned: req=%b mis=%b wbv=%b rw=%b stall=%b berr=%b expected 0/1/1/0/0/0",
                           dmem_req, misaligned, wb_valid, wb_regWrite, stall, bus_error);
    end
    @(negedge clk) clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (misaligned !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL misaligned_pulse: mis=%b wbv=%b expected 0/0", misaligned, wb_valid);
    end
  endtask

  task automatic test_timeout(input bit ack_last);
    bit early_abort = 0;
    @(negedge clk) present(1, 1, 1, 0, 0, 0, 64'h200, 64'h0, 64'h0, 5'd11);
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) clear_inputs();
      if (dmem_req !== 1'b1 || stall !== 1'b1 || wb_valid !== 1'b0) early_abort = 1;
      dmem_ack = ack_last && (i == 16);
      dmem_rdata = 64'hBEEF;
      @(posedge clk); #1;
    end
    checks++;
    if (early_abort) begin failures++; $display("FAIL timeout_early(ack_last=%0d): got abort expected none", ack_last); end
    checks++;
    if (ack_last) begin
      if (wb_valid !== 1'b1 || bus_error !== 1'b0 || wb_read_data !== 64'hBEEF ||
          wb_regWrite !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0) begin
        failures++; $display("FAIL ack_last: wbv=%b berr=%b rdata=%h rw=%b req=%b stall=%b expected 1/0/beef/1/0/0",
                             wb_valid, bus_error, wb_read_data, wb_regWrite, dmem_req, stall);
      end
    end else begin
      if (wb_valid !== 1'b1 || bus_error !== 1'b1 || wb_regWrite !== 1'b0 ||
          dmem_req !== 1'b0 || stall !== 1'b0) begin
        failures++; $display("FAIL timeout: wbv=%b berr=%b rw=%b req=%b stall=%b expected 1/1/0/0/0",
                             wb_valid, bus_error, wb_regWrite, dmem_req, stall);
      end
    end
    @(negedge clk) clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (bus_error !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse: berr=%b wbv=%b expected 0/0", bus_error, wb_valid);
    end
  endtask

  task automatic test_branch();
    @(negedge clk) present(1, 0, 1, 0, 1, 1, 64'h8, 64'h0, 64'h400, 5'd2);
    @(posedge clk); #1;
    checks++;
    if (pc_src !== 1'b1 || pc_target !== 64'h400 || wb_regWrite !== 1'b0 ||
        dmem_req !== 1'b0 || wb_valid !== 1'b1) begin
      failures++; $display("FAIL branch_taken: pc_src=%b tgt=%h rw=%b req=%b wbv=%b expected 1/400/0/0/1",
                           pc_src, pc_target, wb_regWrite, dmem_req, wb_valid);
    end
    @(negedge clk) present(0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 64'h800, 5'd0);
    @(posedge clk); #1;
    checks++;
    if (pc_src !== 1'b0 || pc_target !== 64'h800) begin
      failures++; $display("FAIL branch_not_taken: pc_src=%b tgt=%h expected 0/800", pc_src, pc_target);
    end
    @(negedge clk) clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk) present(1, 1, 1, 0, 0, 0, 64'h300, 64'h0, 64'h0, 5'd6);
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1) begin failures++; $display("FAIL rst_wait_req: got %b expected 1", dmem_req); end
    @(negedge clk) clear_inputs();
    #2 reset = 1;
    #1;
    checks++;
    if ({stall, pc_src, pc_target, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid,
         wb_regWrite, wb_Mem_to_Reg, wb_rd, wb_alu_result, wb_read_data, misaligned,
         bus_error} !== '0) begin
      failures++; $display("FAIL rst_wait_outputs: req=%b stall=%b addr=%h pc_target=%h expected all 0",
                           dmem_req, stall, dmem_addr, pc_target);
    end
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rst_wait_after: req=%b wbv=%b stall=%b expected 0/0/0",
                           dmem_req, wb_valid, stall);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout(0);
    test_timeout(1);
    test_branch();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
